// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with one registered response slot each. Optional counters: ALU_ARB_STATS_EN.

module alu_arbiter_slot #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_wzero,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  // A landing writeback wins over a same-edge consume, keeping the slot full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (i_wr) begin
      r_valid  <= 1'b1;
      r_result <= i_wdata;
      r_zero   <= i_wzero;
    end else if (i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_zero   = r_zero;
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [OPW-1:0]   i_req0_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_result,
  output logic             o_rsp0_zero,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [OPW-1:0]   i_req1_op,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_result,
  output logic             o_rsp1_zero,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [OPW-1:0]   o_alu_op,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_alu_all_zeroes
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      o_stat_issued0,
  output logic [15:0]      o_stat_issued1
`endif
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  req_t [NUM_REQ-1:0]            w_req;
  logic [NUM_REQ-1:0]            w_req_vld;
  logic [NUM_REQ-1:0]            w_rsp_rdy;
  logic [NUM_REQ-1:0]            w_rsp_vld;
  logic [NUM_REQ-1:0][WIDTH-1:0] w_rsp_res;
  logic [NUM_REQ-1:0]            w_rsp_zero;
  logic [NUM_REQ-1:0]            w_elig;
  logic [NUM_REQ-1:0]            w_grant;
  logic                          w_gid;

  logic r_iss_valid;
  logic r_iss_id;
  req_t r_iss;
  logic r_last;

  assign w_req[0]  = '{op: i_req0_op, a: i_req0_a, b: i_req0_b};
  assign w_req[1]  = '{op: i_req1_op, a: i_req1_a, b: i_req1_b};
  assign w_req_vld = {i_req1_valid, i_req0_valid};
  assign w_rsp_rdy = {i_rsp1_ready, i_rsp0_ready};

  genvar n;
  generate
    for (n = 0; n < NUM_REQ; n++) begin : g_req
      // Ineligible while its previous op is in the ALU or its slot stays full.
      assign w_elig[n] = w_req_vld[n]
                       && !(r_iss_valid && (r_iss_id == 1'(n)))
                       && (!w_rsp_vld[n] || w_rsp_rdy[n]);

      alu_arbiter_slot #(.WIDTH(WIDTH)) u_slot (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr     (r_iss_valid && (r_iss_id == 1'(n))),
        .i_wdata  (i_alu_out),
        .i_wzero  (i_alu_all_zeroes),
        .i_ready  (w_rsp_rdy[n]),
        .o_valid  (w_rsp_vld[n]),
        .o_result (w_rsp_res[n]),
        .o_zero   (w_rsp_zero[n])
      );
    end
  endgenerate

  // r_last holds the most recent winner; on a tie the other one is granted.
  always_comb begin
    w_grant = '0;
    if (!i_rst) begin
      if (w_elig == 2'b11) w_grant = r_last ? 2'b01 : 2'b10;
      else                 w_grant = w_elig;
    end
  end

  assign w_gid = w_grant[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_iss_valid <= 1'b0;
      r_iss_id    <= 1'b0;
      r_iss       <= '0;
      r_last      <= 1'b1;
    end else begin
      r_iss_valid <= |w_grant;
      if (|w_grant) begin
        r_iss_id <= w_gid;
        r_iss    <= w_req[w_gid];
        r_last   <= w_gid;
      end
    end
  end

  assign o_req0_ready  = w_grant[0];
  assign o_req1_ready  = w_grant[1];
  assign o_rsp0_valid  = w_rsp_vld[0];
  assign o_rsp0_result = w_rsp_res[0];
  assign o_rsp0_zero   = w_rsp_zero[0];
  assign o_rsp1_valid  = w_rsp_vld[1];
  assign o_rsp1_result = w_rsp_res[1];
  assign o_rsp1_zero   = w_rsp_zero[1];
  assign o_alu_a       = r_iss.a;
  assign o_alu_b       = r_iss.b;
  assign o_alu_op      = r_iss.op;

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_stat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (w_grant[k] && (r_stat[k] != 16'hFFFF)) r_stat[k] <= r_stat[k] + 16'd1;
    end
  end

  assign o_stat_issued0 = r_stat[0];
  assign o_stat_issued1 = r_stat[1];
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with an adder as the ALU model.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat0, stat1;
`endif

  assign alu_out  = alu_a + alu_b;
  assign alu_zero = (alu_out == 32'd0);

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
    .i_req0_a(req0_a), .i_req0_b(req0_b),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready),
    .o_rsp0_result(rsp0_result), .o_rsp0_zero(rsp0_zero),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
    .i_req1_a(req1_a), .i_req1_b(req1_b),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready),
    .o_rsp1_result(rsp1_result), .o_rsp1_zero(rsp1_zero),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_out(alu_out), .i_alu_all_zeroes(alu_zero)
`ifdef ALU_ARB_STATS_EN
    , .o_stat_issued0(stat0), .o_stat_issued1(stat1)
`endif
  );

  typedef struct packed { logic [31:0] r; logic z; } exp_t;
  exp_t q0[$], q1[$];
  int checks = 0, failures = 0;

  // Reference state: which requester has an op in the ALU, whose slot is full,
  // who won last, what the ALU inputs should be, and grant counts.
  bit [1:0]    m_inf, m_full;
  bit          m_last;
  logic [31:0] m_alu_a, m_alu_b;
  logic [3:0]  m_alu_op;
  int          m_cnt0, m_cnt1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return '{r: s, z: (s == 32'd0)};
  endfunction

  task automatic step();
    bit [1:0] v, rr, el, gr;
    @(negedge clk);
    v  = {req1_valid, req0_valid};
    rr = {rsp1_ready, rsp0_ready};
    for (int n = 0; n < 2; n++) el[n] = v[n] && !m_inf[n] && (!m_full[n] || rr[n]);
    gr = 2'b00;
    if (!rst) gr = (el == 2'b11) ? (m_last ? 2'b01 : 2'b10) : el;
    chk("req0_ready", req0_ready, gr[0]);
    chk("req1_ready", req1_ready, gr[1]);
    chk("rsp0_valid", rsp0_valid, m_full[0]);
    chk("rsp1_valid", rsp1_valid, m_full[1]);
    chk("alu_a", alu_a, m_alu_a);
    chk("alu_b", alu_b, m_alu_b);
    chk("alu_op", alu_op, m_alu_op);
`ifdef ALU_ARB_STATS_EN
    chk("stat0", stat0, m_cnt0);
    chk("stat1", stat1, m_cnt1);
`endif
    if (gr[0]) q0.push_back(mk(req0_a, req0_b));
    if (gr[1]) q1.push_back(mk(req1_a, req1_b));
    @(posedge clk);
    if (rst) begin
      m_inf = 0; m_full = 0; m_last = 1'b1;
      m_alu_a = 0; m_alu_b = 0; m_alu_op = 0;
      m_cnt0 = 0; m_cnt1 = 0;
      q0.delete(); q1.delete();
    end else begin
      for (int n = 0; n < 2; n++) m_full[n] = m_inf[n] ? 1'b1 : (rr[n] ? 1'b0 : m_full[n]);
      m_inf = gr;
      if (gr[0]) begin
        m_last = 1'b0; m_alu_a = req0_a; m_alu_b = req0_b; m_alu_op = req0_op;
        if (m_cnt0 < 16'hFFFF) m_cnt0++;
      end else if (gr[1]) begin
        m_last = 1'b1; m_alu_a = req1_a; m_alu_b = req1_b; m_alu_op = req1_op;
        if (m_cnt1 < 16'hFFFF) m_cnt1++;
      end
    end
    #1;
  endtask

  // Monitor: every consumed response is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp0_valid && rsp0_ready) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp0_unexpected: got result %0h expected no response", rsp0_result);
      end else begin
        e = q0.pop_front();
        chk("rsp0_result", rsp0_result, e.r);
        chk("rsp0_zero", rsp0_zero, e.z);
      end
    end
    if (!rst && rsp1_valid && rsp1_ready) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp1_unexpected: got result %0h expected no response", rsp1_result);
      end else begin
        e = q1.pop_front();
        chk("rsp1_result", rsp1_result, e.r);
        chk("rsp1_zero", rsp1_zero, e.z);
      end
    end
  end

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  initial begin
    m_inf = 0; m_full = 0; m_last = 1'b1;
    m_alu_a = 0; m_alu_b = 0; m_alu_op = 0; m_cnt0 = 0; m_cnt1 = 0;
    idle();
    rsp0_ready = 1; rsp1_ready = 1;
    rst = 1;
    req0_valid = 1; req1_valid = 1;
    step(); step();
    rst = 0; idle();
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp0_zero", rsp0_zero, 0);
    chk("rst_rsp1_result", rsp1_result, 0);
    chk("rst_rsp1_zero", rsp1_zero, 0);

    // Single op: 5 + 7
    req0_valid = 1; req0_op = 4'h2; req0_a = 5; req0_b = 7;
    step();
    idle();
    step(); step(); step();

    // Wraparound to zero on requester 1
    req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 1;
    step();
    idle();
    step(); step();

    // Both held valid: alternating grants
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom);
      step();
    end

    // Backpressure on requester 0 only
    rsp0_ready = 0;
    for (int i = 0; i < 6; i++) begin
      req0_a = $urandom; req1_a = $urandom;
      step();
    end
    if (q0.size() > 0) chk("rsp0_hold", rsp0_result, q0[0].r);
    rsp0_ready = 1;
    step(); step(); step();

    // Reset one edge after a req0 grant drops the op
    idle();
    step(); step(); step();
    req0_valid = 1; req0_a = 9; req0_b = 9;
    step();
    idle(); rst = 1;
    step();
    rst = 0;
    chk("rst2_rsp0_result", rsp0_result, 0);
    chk("rst2_alu_a", alu_a, 0);
    step(); step();
    req0_valid = 1; req1_valid = 1; req0_a = 1; req1_a = 2;
    step();
    idle();
    step(); step();

    // Randomized traffic with backpressure and occasional resets
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      req0_op = 4'($urandom); req1_op = 4'($urandom);
      req0_a = $urandom; req1_a = $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? -req0_a : $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? -req1_a : $urandom;
      step();
    end

    rst = 0; idle(); rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 5; i++) step();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
